instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage of the RV32 core: owns the program counter, drives the
//  instruction-memory address, captures the combinational read data into a
//  small {pc,instr} queue and hands entries to decode via valid/ready.
//  Accepts redirects (branch/jump) from execute, flushing queued work.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; word-aligned.
//  DEPTH     2              Fetch queue entries; power of two, >= 2.
// PORTS
//  clk             in   1   Rising-edge clock.
//  reset           in   1   Asynchronous, active-high.
//  fetch_en        in   1   Permit new fetches.
//  imem_pc         out  32  Address to instruction memory (= pc_q).
//  imem_instr      in   32  Instruction word at imem_pc, same cycle.
//  redirect_valid  in   1   Redirect request, single-cycle pulse.
//  redirect_pc     in   32  Redirect target.
//  dec_valid       out  1   Queue head valid.
//  dec_ready       in   1   Decode accepts head.
//  dec_instr       out  32  Head instruction.
//  dec_pc          out  32  Head PC.
//  fault           out  1   Sticky misaligned-redirect fault.
//  fault_pc        out  32  Offending redirect_pc.
// BEHAVIOUR
//  - Reset (async): pc_q=RESET_PC, queue empty, all entries 0, dec_valid=0,
//    dec_instr=0, dec_pc=0, fault=0, fault_pc=0, state=IDLE.
//  - FSM: IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0;
//    IDLE/RUN->HALT on misaligned redirect; HALT exits only via reset.
//  - Enqueue when state==RUN && fetch_en && count<DEPTH && !redirect_valid:
//    push {pc_q, imem_instr}; pc_q<=pc_q+4 (mod 2^32, 0xFFFF_FFFC->0).
//  - Full blocks enqueue even if a dequeue occurs the same cycle (no bypass).
//  - Dequeue on dec_valid && dec_ready; dec_valid = (count!=0).
//  - Latency: word at imem_pc appears on dec_* the cycle after capture.
//  - Simultaneous enq+deq when 0<count<DEPTH: count unchanged, order kept.
//  - IDLE: no enqueue; queued entries still drain to decode.
//  - Redirect, redirect_pc[1:0]==0 (IDLE/RUN): queue flushed (count=0),
//    pc_q<=redirect_pc, no enqueue/dequeue credited that cycle.
//  - Redirect, redirect_pc[1:0]!=0: flush, fault<=1, fault_pc<=redirect_pc,
//    state<=HALT; pc_q unchanged.
//  - HALT: no enqueue, dec_valid=0, redirects ignored.
//  - Redirect has priority over enqueue, dequeue and fetch_en.
// CONFIGURATION
//  FETCH_PERF_EN defined: extra port fetch_count out 32, reset 0, +1 per
//    dequeue handshake, wraps at 2^32; flushed entries not counted.
//  FETCH_PERF_EN undefined: port and counter absent; no other change.
// STRUCTURE
//  fetch_pkg: fetch_state_e {IDLE,RUN,HALT}, fetch_entry_t {pc,instr},
//    INSTR_W=32, PC_STEP=4.
//  Sub-module fetch_fifo: DEPTH-entry circular queue of fetch_entry_t with
//    push/pop/flush, count, async reset; FSM and PC logic stay here.
// TESTING
//  1 fetch_en=1, dec_ready=1, imem holds addi x1,10/addi x2,11/add x3 ->
//    dec_pc 0,4,8 with matching words on consecutive cycles, no gaps.
//  2 dec_ready=0 from start -> after 2 pushes imem_pc holds 0x8;
//    raise dec_ready -> 0x0,0x4,0x8 in order, no drop/duplicate.
//  3 2 entries queued, redirect_pc=0x40 -> dec_valid=0 next cycle, then
//    dec_pc=0x40,0x44.
//  4 redirect_pc=0x42 -> fault=1, fault_pc=0x42, dec_valid=0, imem_pc
//    frozen; later aligned redirect 0x80 ignored.
//  5 reset asserted mid-RUN between edges -> outputs at reset values
//    immediately, imem_pc=RESET_PC; restart fetches from RESET_PC.
//  6 FETCH_PERF_EN: 5 handshakes then redirect flushing 2 entries ->
//    fetch_count=5; build without macro compiles with port absent.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 fetch stage.
//   fetch_state_e : IDLE / RUN / HALT fetch control state
//   fetch_entry_t : one queued {pc, instr} pair handed to decode
package fetch_pkg;
    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Circular queue of fetch entries between instruction memory and decode.
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-high reset
//   push, din     write din at the tail (caller guarantees not full)
//   pop           drop the head (caller guarantees not empty)
//   flush         empty the queue; takes priority over push/pop
//   head          entry at the read pointer (stale when count==0)
//   count         number of valid entries, 0..DEPTH
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           din,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Entries are left in place; they are unreachable once count is 0.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;   // DEPTH is a power of two: natural wrap
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// File: rtl/instruction_fetch.sv
// RV32 fetch stage: owns the PC, addresses instruction memory, captures the
// same-cycle read data into a small queue and presents the head to decode
// with valid/ready. Execute may redirect the PC, flushing queued work; a
// misaligned redirect target latches a sticky fault and halts fetch until
// reset.
// Ports:
//   clk, reset                rising-edge clock, asynchronous active-high reset
//   fetch_en                  permit new fetches (IDLE<->RUN)
//   imem_pc / imem_instr      memory address (= pc) / combinational read data
//   redirect_valid/_pc        single-cycle redirect request and target
//   dec_valid/_ready          queue head handshake to decode
//   dec_instr / dec_pc        queue head contents
//   fault / fault_pc          sticky misaligned-redirect flag and target
//   fetch_count               (FETCH_PERF_EN only) decode handshakes, wraps
// Build option: define FETCH_PERF_EN to add the fetch_count port/counter.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0] fetch_count,
`endif
    output logic        fault,
    output logic [31:0] fault_pc
);
    localparam int                CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]     FULL = CW'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  din;
    logic          redir;       // redirect that is acted on (not in HALT)
    logic          misaligned;
    logic          enq, deq;

    assign redir      = redirect_valid && (state_q != HALT);
    assign misaligned = (redirect_pc[1:0] != 2'b00);

    // Full blocks enqueue even when decode drains the head this cycle.
    assign enq = (state_q == RUN) && fetch_en && (count < FULL) && !redirect_valid;
    // HALT always has an empty queue (entered via flush), the gate is belt-and-braces.
    assign dec_valid = (state_q != HALT) && (count != '0);
    assign deq       = dec_valid && dec_ready && !redirect_valid;

    assign din       = '{pc: pc_q, instr: imem_instr};
    assign imem_pc   = pc_q;
    assign dec_pc    = head.pc;
    assign dec_instr = head.instr;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (enq),
        .pop   (deq),
        .flush (redir),
        .din   (din),
        .head  (head),
        .count (count)
    );

    // A redirect cycle overrides fetch_en, so no IDLE/RUN change happens then.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (redir && misaligned)               state_d = HALT;
                  else if (!redirect_valid && fetch_en)  state_d = RUN;
            RUN:  if (redir && misaligned)               state_d = HALT;
                  else if (!redirect_valid && !fetch_en) state_d = IDLE;
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            fault    <= 1'b0;
            fault_pc <= '0;
        end else begin
            state_q <= state_d;
            if (redir) begin
                if (misaligned) begin
                    fault    <= 1'b1;
                    fault_pc <= redirect_pc;
                end else begin
                    pc_q <= redirect_pc;
                end
            end else if (enq) begin
                pc_q <= pc_q + PC_STEP;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    fetch_count <= '0;
        else if (deq) fetch_count <= fetch_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_en = 1'b0;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        fault;
    logic [31:0] fault_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
`endif

    instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
`ifdef FETCH_PERF_EN
        .fetch_count    (fetch_count),
`endif
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    // Instruction memory: a short program at 0/4/8, a hash everywhere else.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00A0_0093;   // addi x1, x0, 10
            32'h4:   return 32'h00B0_0113;   // addi x2, x0, 11
            32'h8:   return 32'h0020_81B3;   // add  x3, x1, x2
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction
    assign imem_instr = mem_word(imem_pc);

    // Reference model: an in-order list of fetched {pc,instr} plus flags.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t        q[$];
    bit          m_run, m_halt, m_fault;
    logic [31:0] m_pc, m_fpc, m_cnt;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_run = 0; m_halt = 0; m_fault = 0;
        m_pc = RESET_PC; m_fpc = '0; m_cnt = '0;
    endtask

    task automatic check_all();
        chk("imem_pc", imem_pc, m_pc);
        chk("dec_valid", {31'b0, dec_valid}, {31'b0, (!m_halt && q.size() != 0)});
        if (!m_halt && q.size() != 0) begin
            chk("dec_pc", dec_pc, q[0].pc);
            chk("dec_instr", dec_instr, q[0].instr);
        end
        chk("fault", {31'b0, fault}, {31'b0, m_fault});
        chk("fault_pc", fault_pc, m_fpc);
`ifdef FETCH_PERF_EN
        chk("fetch_count", fetch_count, m_cnt);
`endif
    endtask

    // Called at a negedge: drive inputs, advance the model across the next
    // rising edge, then check at the following negedge.
    task automatic step(input bit fe, input bit rv, input logic [31:0] rpc, input bit rdy);
        bit can_enq;
        fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; dec_ready = rdy;
        if (!m_halt) begin
            if (rv) begin
                q.delete();
                if (rpc[1:0] == 2'b00) m_pc = rpc;
                else begin
                    m_fault = 1; m_fpc = rpc; m_halt = 1;
                end
            end else begin
                can_enq = m_run && fe && (q.size() < DEPTH);
                if (q.size() != 0 && rdy) begin
                    void'(q.pop_front());
                    m_cnt = m_cnt + 32'd1;
                end
                if (can_enq) begin
                    q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
                m_run = fe;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        fetch_en = 0; redirect_valid = 0; redirect_pc = '0; dec_ready = 0;
        reset = 1;
        #1;
        model_reset();
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_dec_instr", dec_instr, 32'h0);
        check_all();
        @(negedge clk);
        reset = 0;
    endtask

    logic [31:0] frozen;
    logic [31:0] rpc;

    initial begin
        @(negedge clk);

        // 1: straight-line program streams to decode without gaps.
        do_reset();
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("t1_pc0", dec_pc, 32'h0);  chk("t1_i0", dec_instr, 32'h00A0_0093);
        step(1, 0, 0, 1);
        chk("t1_pc1", dec_pc, 32'h4);  chk("t1_i1", dec_instr, 32'h00B0_0113);
        step(1, 0, 0, 1);
        chk("t1_pc2", dec_pc, 32'h8);  chk("t1_i2", dec_instr, 32'h0020_81B3);

        // 2: decode stalled; queue fills, then drains in order.
        do_reset();
        repeat (4) step(1, 0, 0, 0);
        chk("t2_full_pc", imem_pc, 32'h8);
        chk("t2_head0", dec_pc, 32'h0);
        step(1, 0, 0, 1);
        chk("t2_head1", dec_pc, 32'h4);
        step(1, 0, 0, 1);
        chk("t2_head2", dec_pc, 32'h8);

        // 3: aligned redirect flushes queued entries.
        do_reset();
        repeat (3) step(1, 0, 0, 0);
        step(1, 1, 32'h40, 0);
        chk("t3_flush", {31'b0, dec_valid}, 32'h0);
        step(1, 0, 0, 1);
        chk("t3_pc40", dec_pc, 32'h40);
        step(1, 0, 0, 1);
        chk("t3_pc44", dec_pc, 32'h44);

        // 4: misaligned redirect halts; later redirects are ignored.
        step(1, 1, 32'h42, 1);
        frozen = imem_pc;
        chk("t4_fault", {31'b0, fault}, 32'h1);
        chk("t4_fpc", fault_pc, 32'h42);
        step(1, 1, 32'h80, 1);
        step(1, 0, 0, 1);
        chk("t4_frozen", imem_pc, frozen);
        chk("t4_novalid", {31'b0, dec_valid}, 32'h0);

        // 5: asynchronous reset between edges while running.
        do_reset();
        repeat (4) step(1, 0, 0, 1);
        @(posedge clk);
        #2 reset = 1;
        #1;
        model_reset();
        chk("t5_pc", imem_pc, RESET_PC);
        chk("t5_dpc", dec_pc, 32'h0);
        check_all();
        @(negedge clk);
        reset = 0; fetch_en = 0; dec_ready = 0;
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("t5_restart", dec_pc, RESET_PC);

        // PC wraps from 0xFFFF_FFFC to 0.
        do_reset();
        step(0, 1, 32'hFFFF_FFF8, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("wrap_a", dec_pc, 32'hFFFF_FFF8);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("wrap_0", dec_pc, 32'h0);
        chk("wrap_pc", imem_pc, 32'h4);

`ifdef FETCH_PERF_EN
        // 6: five handshakes, then a flush of two entries is not counted.
        do_reset();
        repeat (7) step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        step(1, 1, 32'h100, 1);
        chk("t6_count", fetch_count, 32'd5);
`endif

        // Randomized episodes against the model.
        for (int e = 0; e < 6; e++) begin
            do_reset();
            for (int i = 0; i < 300; i++) begin
                rpc = $urandom;
                if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
                step($urandom_range(7) != 0, $urandom_range(15) == 0, rpc,
                     $urandom_range(2) != 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
